// File: rtl/ram_arbiter_if.sv
// Bundles the two requester ports and the RAM port.
// slave = arbiter side; master = requesters plus RAM model.
interface ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              a_req, a_we, a_lock;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt, a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req, b_we, b_lock;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt, b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    modport slave (
        input  a_req, a_we, a_lock, a_addr, a_wdata,
        input  b_req, b_we, b_lock, b_addr, b_wdata,
        input  ram_rdata,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr
    );

    modport master (
        output a_req, a_we, a_lock, a_addr, a_wdata,
        output b_req, b_we, b_lock, b_addr, b_wdata,
        output ram_rdata,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM between fetch (A) and load/store (B).
// Zero-latency grant, bounded locked bursts, read data routed by a
// one-cycle valid pipe that tracks the 1-cycle RAM read latency.
module ram_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  arb
);
    localparam int CNT_W = $clog2(LOCK_MAX) + 1;

    // Lock state folds lock_active and lock_owner into one encoding.
    typedef enum logic [1:0] {ST_FREE, ST_LOCK_A, ST_LOCK_B} lock_st_t;

    lock_st_t          r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_lock_cnt, w_cnt_nxt, w_cnt_inc;
    logic              r_rr_ptr;
    logic              r_rv_a, r_rv_b;

    logic              w_gnt_a, w_gnt_b, w_any;
    logic              w_we, w_lock;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // Grant decision: lock owner first, then a lone requester, then rr_ptr.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!rst) begin
            if (r_state == ST_LOCK_A && arb.a_req)      w_gnt_a = 1'b1;
            else if (r_state == ST_LOCK_B && arb.b_req) w_gnt_b = 1'b1;
            else if (arb.a_req && arb.b_req) begin
                if (r_rr_ptr) w_gnt_b = 1'b1;
                else          w_gnt_a = 1'b1;
            end
            else if (arb.a_req) w_gnt_a = 1'b1;
            else if (arb.b_req) w_gnt_b = 1'b1;
        end
    end

    assign w_any   = w_gnt_a | w_gnt_b;
    assign w_we    = w_gnt_a ? arb.a_we   : (w_gnt_b & arb.b_we);
    assign w_lock  = w_gnt_a ? arb.a_lock : (w_gnt_b & arb.b_lock);
    assign w_addr  = w_gnt_a ? arb.a_addr  : (w_gnt_b ? arb.b_addr  : '0);
    assign w_wdata = w_gnt_a ? arb.a_wdata : (w_gnt_b ? arb.b_wdata : '0);

    // A locked grant continues the count only if the same port already holds the lock.
    assign w_cnt_inc = ((r_state == ST_LOCK_A && w_gnt_a) || (r_state == ST_LOCK_B && w_gnt_b))
                       ? r_lock_cnt + CNT_W'(1) : CNT_W'(1);

    // Next lock state: any unlocked grant, idle cycle or reaching the bound frees it.
    always_comb begin
        w_state_nxt = ST_FREE;
        w_cnt_nxt   = '0;
        if (w_any && w_lock && (w_cnt_inc < CNT_W'(LOCK_MAX))) begin
            w_state_nxt = w_gnt_b ? ST_LOCK_B : ST_LOCK_A;
            w_cnt_nxt   = w_cnt_inc;
        end
    end

    // Lock state, round-robin pointer and read-valid pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FREE;
            r_lock_cnt <= '0;
            r_rr_ptr   <= 1'b0;
            r_rv_a     <= 1'b0;
            r_rv_b     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_cnt_nxt;
            if (w_any) r_rr_ptr <= w_gnt_a;
            r_rv_a     <= w_gnt_a & ~arb.a_we;
            r_rv_b     <= w_gnt_b & ~arb.b_we;
        end
    end

    assign arb.a_gnt     = w_gnt_a;
    assign arb.b_gnt     = w_gnt_b;
    assign arb.a_rvalid  = r_rv_a;
    assign arb.b_rvalid  = r_rv_b;
    assign arb.a_rdata   = arb.ram_rdata;
    assign arb.b_rdata   = arb.ram_rdata;

    assign arb.ram_we    = w_any & w_we;
    assign arb.ram_re    = w_any & ~w_we;
    assign arb.ram_waddr = w_addr;
    assign arb.ram_raddr = w_addr;
    assign arb.ram_wdata = w_wdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a registered-read RAM model.
module tb_ram_arbiter;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    ram_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: write at the edge, 1-cycle registered read.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
        if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_a(input logic req, input logic we, input logic lock,
                         input logic [7:0] addr, input logic [7:0] wdata);
        bus.a_req = req; bus.a_we = we; bus.a_lock = lock;
        bus.a_addr = addr; bus.a_wdata = wdata;
    endtask

    task automatic set_b(input logic req, input logic we, input logic lock,
                         input logic [7:0] addr, input logic [7:0] wdata);
        bus.b_req = req; bus.b_we = we; bus.b_lock = lock;
        bus.b_addr = addr; bus.b_wdata = wdata;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Check which port (0 none, 1 A, 2 B) is granted, mid-cycle.
    task automatic chk_gnt(input string tag, input int exp);
        chk(tag, {30'd0, bus.b_gnt, bus.a_gnt}, exp);
    endtask

    initial begin
        int exp_lock [6];
        n_chk  = 0;
        n_fail = 0;
        bus.ram_rdata = 8'h00;

        // Reset with both ports requesting writes.
        rst = 1'b1;
        set_a(1, 1, 0, 8'h10, 8'h11);
        set_b(1, 1, 0, 8'h20, 8'h22);
        for (int i = 0; i < 3; i++) begin
            #4;
            chk_gnt("rst_gnt", 0);
            chk("rst_ram_we", bus.ram_we, 0);
            if (i > 0) chk("rst_rvalid", {bus.a_rvalid, bus.b_rvalid}, 0);
            tick;
        end
        rst = 1'b0;
        #4;
        chk_gnt("post_rst_first", 1);
        chk("post_rst_we", bus.ram_we, 1);
        chk("post_rst_waddr", bus.ram_waddr, 8'h10);
        chk("post_rst_wdata", bus.ram_wdata, 8'h11);
        tick;
        #4;
        chk_gnt("post_rst_second", 2);
        chk("b_waddr", bus.ram_waddr, 8'h20);
        tick;

        // Contention: continuous reads alternate A, B, A, B.
        set_a(1, 0, 0, 8'h10, 8'h00);
        set_b(1, 0, 0, 8'h20, 8'h00);
        #4; chk_gnt("rr0", 1); chk("rr0_re", bus.ram_re, 1); chk("rr0_raddr", bus.ram_raddr, 8'h10);
        tick;
        #4; chk_gnt("rr1", 2); chk("rr1_raddr", bus.ram_raddr, 8'h20);
        chk("rr1_arv", {bus.a_rvalid, bus.b_rvalid}, 2'b10); chk("rr1_adata", bus.a_rdata, 8'h11);
        tick;
        #4; chk_gnt("rr2", 1);
        chk("rr2_brv", {bus.a_rvalid, bus.b_rvalid}, 2'b01); chk("rr2_bdata", bus.b_rdata, 8'h22);
        tick;
        #4; chk_gnt("rr3", 2);
        chk("rr3_arv", {bus.a_rvalid, bus.b_rvalid}, 2'b10); chk("rr3_adata", bus.a_rdata, 8'h11);
        tick;
        set_a(0, 0, 0, 8'h00, 8'h00);
        set_b(0, 0, 0, 8'h00, 8'h00);
        #4; chk_gnt("idle_gnt", 0);
        chk("idle_brv", {bus.a_rvalid, bus.b_rvalid}, 2'b01); chk("idle_bdata", bus.b_rdata, 8'h22);
        chk("idle_addr0", bus.ram_waddr, 8'h00);
        chk("idle_re", bus.ram_re, 0);
        tick;

        // Write then read of the same address on consecutive cycles.
        set_b(1, 1, 0, 8'h33, 8'h5A);
        #4; chk_gnt("raw_wr", 2); chk("raw_we", bus.ram_we, 1);
        tick;
        set_b(0, 0, 0, 8'h00, 8'h00);
        set_a(1, 0, 0, 8'h33, 8'h00);
        #4; chk_gnt("raw_rd", 1); chk("raw_rd_addr", bus.ram_raddr, 8'h33);
        tick;
        set_a(0, 0, 0, 8'h00, 8'h00);
        #4; chk("raw_arv", {bus.a_rvalid, bus.b_rvalid}, 2'b10);
        chk("raw_data", bus.a_rdata, 8'h5A);
        tick;

        // Lock bound: B locked for 4 grants, then A, then B again.
        exp_lock = '{2, 2, 2, 2, 1, 2};
        for (int i = 0; i < 6; i++) begin
            set_b(1, 0, (i < 5), 8'h20, 8'h00);
            set_a((i > 0), 0, 0, 8'h10, 8'h00);
            #4; chk_gnt($sformatf("lock_bound%0d", i), exp_lock[i]);
            tick;
        end
        set_a(0, 0, 0, 8'h00, 8'h00);
        set_b(0, 0, 0, 8'h00, 8'h00);
        tick;

        // Lock drop: A locks, holds against B, then drops req.
        set_a(1, 0, 1, 8'h10, 8'h00);
        #4; chk_gnt("drop0", 1);
        tick;
        set_b(1, 0, 0, 8'h20, 8'h00);
        #4; chk_gnt("drop1_held", 1);
        tick;
        set_a(0, 0, 0, 8'h00, 8'h00);
        #4; chk_gnt("drop2_b", 2);
        tick;
        set_a(1, 0, 0, 8'h10, 8'h00);
        #4; chk_gnt("drop3_rr", 1);
        tick;
        set_a(0, 0, 0, 8'h00, 8'h00);
        set_b(0, 0, 0, 8'h00, 8'h00);
        tick;

        // Reset mid-read.
        set_a(1, 0, 0, 8'h33, 8'h00);
        #4; chk_gnt("mr_gnt", 1);
        tick;
        rst = 1'b1;
        #4; chk_gnt("mr_rst_gnt", 0);
        chk("mr_rv_n1", bus.a_rvalid, 1); chk("mr_data", bus.a_rdata, 8'h5A);
        tick;
        #4; chk_gnt("mr_rst_gnt2", 0);
        chk("mr_rv_n2", bus.a_rvalid, 0);
        tick;
        rst = 1'b0;
        set_b(1, 0, 0, 8'h20, 8'h00);
        #4; chk_gnt("mr_ptr_cleared", 1);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter that shares the single data RAM between the instruction-fetch requester (port A) and the load/store requester (port B). It grants at most one RAM operation per cycle, supports short locked bursts with a bounded hold length, and routes registered read data back to the requester that issued the read. It sits between the core's fetch and load/store units and the RAM's write and read ports. The RAM has 1-cycle registered read latency.

## Interface

- ADDR_W, 8, address width
- DATA_W, 8, data width
- LOCK_MAX, 4, maximum consecutive grants to one port while locked (≥2)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- a_req / b_req  in  1  request valid
- a_we / b_we  in  1  1 = write, 0 = read
- a_lock / b_lock  in  1  request to keep the grant on the next cycle
- a_addr / b_addr  in  ADDR_W  address
- a_wdata / b_wdata  in  DATA_W  write data
- a_gnt / b_gnt  out  1  request accepted this cycle (combinational)
- a_rvalid / b_rvalid  out  1  read data valid (registered)
- a_rdata / b_rdata  out  DATA_W  read data (= ram_rdata, qualified by rvalid)
- ram_we  out  1  RAM write enable
- ram_waddr  out  ADDR_W  RAM write address
- ram_wdata  out  DATA_W  RAM write data
- ram_re  out  1  RAM read enable
- ram_raddr  out  ADDR_W  RAM read address
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_re

## Operation

- State: rr_ptr (0 = A preferred, 1 = B), lock_active, lock_owner, lock_cnt (counts consecutive locked grants, width clog2(LOCK_MAX)+1), rv_a, rv_b.
- Grant decision, priority order:
  - If lock_active and lock_owner's req = 1, grant the owner.
  - Otherwise, if only one req is high, grant it.
  - If both are high, grant the port selected by rr_ptr.
  - If neither is high, grant nothing.
- a_gnt and b_gnt are never both 1. Both are 0 while rst = 1.
- On every grant, rr_ptr points to the other port.
- Lock:
  - A grant with lock = 1 sets lock_active and lock_owner for the next cycle, and increments lock_cnt. A first locked grant sets lock_cnt = 1.
  - When lock_cnt reaches LOCK_MAX on a grant, lock_active clears and lock_cnt returns to 0, regardless of lock. The other port, if requesting, wins the next cycle via rr_ptr.
  - A grant with lock = 0, an owner req drop, or a cycle with no grant clears lock_active and lock_cnt.
- RAM drive:
  - ram_we = gnt & we; ram_re = gnt & ~we. Both are 0 when there is no grant.
  - ram_waddr, ram_raddr and ram_wdata mux from the winner. They are all-zero when there is no grant.
- Read return:
  - rv_x <= gnt_x & ~we_x; x_rvalid = rv_x.
  - a_rdata = b_rdata = ram_rdata, unregistered.
- Read-after-write to the same address on consecutive grants returns the newly written data, because the RAM writes at the edge.

## Timing

- Reset values: all outputs 0 (gnt, rvalid, ram_we, ram_re, addresses, wdata); rr_ptr = 0; lock_active = 0; lock_cnt = 0.
- ram_we is gated by rst, so the RAM never sees a write during reset.
- Grant latency is 0 cycles: gnt follows req in the same cycle. The requester holds its request fields stable while req = 1 and treats gnt as the transfer point.
- Read latency: grant in cycle N gives x_rvalid = 1 with data in cycle N+1. Back-to-back reads give rvalid every cycle.
- Reset mid-operation: a read granted in cycle N with rst high in N+1 still shows rvalid in N+1. rvalid is 0 from N+2. Lock and pointer state are cleared at that edge.
- Throughput: one RAM operation per cycle, fully pipelined.

## Test plan

- Reset: hold rst for 3 cycles with both ports requesting writes -> gnt = 0 and ram_we = 0 throughout; after release, A is granted first (rr_ptr = 0).
- Contention: A and B request reads continuously at 0x10 and 0x20 -> grants alternate A, B, A, B; each rvalid arrives one cycle after its grant with the correct port's data.
- Write then read: B writes 0x5A to 0x33 in cycle N; A reads 0x33 in N+1 -> a_rvalid = 1 in N+2 with a_rdata = 0x5A.
- Lock bound: B holds lock = 1 with reads while A requests continuously, LOCK_MAX = 4 -> B is granted 4 consecutive cycles, then A, then B resumes.
- Lock drop: A locked, then drops req while B requests -> B is granted in that same cycle and lock_active clears.
- Reset mid-read: A read granted in N, rst high in N+1 -> a_rvalid = 1 in N+1, 0 in N+2; no grants while rst = 1.
